transpose_stream: RTL and testbench

//   Streaming matrix transpose. Accepts an INPUT_SHAPE_1 x INPUT_SHAPE_2 matrix one element per beat in
//   row-major order over valid/ready, buffers it, and emits the INPUT_SHAPE_2 x INPUT_SHAPE_1 transpose
//   in row-major order (input column-major). Serial counterpart of the flat-bus op_trans transpose, used

---
 rtl/transpose_stream_if.sv | 36 +++
 rtl/transpose_stream.sv | 163 ++++++++++++++++
 tb/tb_transpose_stream.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/transpose_stream_if.sv
// Element-stream bundle for transpose_stream: input and output valid/ready channels.
// The slave modport is the transpose block; the master modport is its environment.
interface transpose_stream_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_row_last;
    logic                         out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_row_last,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_row_last,
        output out_last
    );
endinterface

// File: rtl/transpose_stream.sv
// Streaming R x C matrix transpose: row-major in, column-major out, one element per beat.
// Define TRANSPOSE_STREAM_PINGPONG_EN for two buffer banks so fill and drain overlap.
module transpose_stream #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned INPUT_SHAPE_1 = 4,
    parameter int unsigned INPUT_SHAPE_2 = 6
) (
    input logic                clk_p,
    input logic                rst_p,
    transpose_stream_if.slave  io_stream
);
    localparam int unsigned R  = INPUT_SHAPE_1;
    localparam int unsigned C  = INPUT_SHAPE_2;
    localparam int unsigned N  = R * C;
`ifdef TRANSPOSE_STREAM_PINGPONG_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif
    localparam int unsigned AW = (NB * N > 1) ? $clog2(NB * N) : 1;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned JW = (C > 1) ? $clog2(C) : 1;

    logic [DATA_WIDTH-1:0] r_mem [NB*N];

    logic [CW-1:0] r_wa;
    logic [CW-1:0] r_ra;
    logic [IW-1:0] r_i;
    logic [JW-1:0] r_j;

    logic          w_in_ready_raw;
    logic          w_out_valid_raw;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_fill_done;
    logic          w_drain_done;
    logic          w_i_last;
    logic          w_j_last;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;

    assign w_in_ready   = !rst_p && w_in_ready_raw;
    assign w_out_valid  = !rst_p && w_out_valid_raw;
    assign w_in_fire    = io_stream.in_valid && w_in_ready;
    assign w_out_fire   = w_out_valid && io_stream.out_ready;
    assign w_i_last     = (r_i == IW'(R - 1));
    assign w_j_last     = (r_j == JW'(C - 1));
    assign w_fill_done  = w_in_fire && (r_wa == CW'(N - 1));
    assign w_drain_done = w_out_fire && w_i_last && w_j_last;

`ifdef TRANSPOSE_STREAM_PINGPONG_EN
    logic [1:0] r_full;
    logic       r_wb;
    logic       r_rb;

    assign w_in_ready_raw  = !r_full[r_wb];
    assign w_out_valid_raw = r_full[r_rb];
    assign w_waddr = AW'(r_wa) + (r_wb ? AW'(N) : AW'(0));
    assign w_raddr = AW'(r_ra) + (r_rb ? AW'(N) : AW'(0));

    // A fill needs !full[wb] and a drain needs full[rb], so both completing
    // in one cycle always touch different banks.
    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            r_full <= 2'b00;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
        end else begin
            if (w_fill_done) begin
                r_full[r_wb] <= 1'b1;
                r_wb         <= ~r_wb;
            end
            if (w_drain_done) begin
                r_full[r_rb] <= 1'b0;
                r_rb         <= ~r_rb;
            end
        end
    end
`else
    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e r_state;
    logic   r_in_rdy;
    logic   r_out_vld;

    assign w_in_ready_raw  = r_in_rdy;
    assign w_out_valid_raw = r_out_vld;
    assign w_waddr         = AW'(r_wa);
    assign w_raddr         = AW'(r_ra);

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            r_state   <= StFill;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
        end else begin
            case (r_state)
                StFill: begin
                    if (w_fill_done) begin
                        r_state   <= StDrain;
                        r_in_rdy  <= 1'b0;
                        r_out_vld <= 1'b1;
                    end
                end
                StDrain: begin
                    if (w_drain_done) begin
                        r_state   <= StFill;
                        r_in_rdy  <= 1'b1;
                        r_out_vld <= 1'b0;
                    end
                end
            endcase
        end
    end
`endif

    // Buffer contents are intentionally not reset; stale data is never read
    // because a bank only drains after a complete fill.
    always_ff @(posedge clk_p) begin
        if (w_in_fire) begin
            r_mem[w_waddr] <= io_stream.in_data;
        end
    end

    // r_ra tracks i*C + j incrementally: step by C down a column, then wrap to j+1.
    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            r_wa <= '0;
            r_ra <= '0;
            r_i  <= '0;
            r_j  <= '0;
        end else begin
            if (w_in_fire) begin
                r_wa <= w_fill_done ? '0 : r_wa + CW'(1);
            end
            if (w_out_fire) begin
                if (w_i_last) begin
                    r_i <= '0;
                    if (w_j_last) begin
                        r_j  <= '0;
                        r_ra <= '0;
                    end else begin
                        r_j  <= r_j + JW'(1);
                        r_ra <= CW'(r_j) + CW'(1);
                    end
                end else begin
                    r_i  <= r_i + IW'(1);
                    r_ra <= r_ra + CW'(C);
                end
            end
        end
    end

    assign io_stream.in_ready     = w_in_ready;
    assign io_stream.out_valid    = w_out_valid;
    assign io_stream.out_data     = w_out_valid ? r_mem[w_raddr] : '0;
    assign io_stream.out_row_last = w_out_valid && w_i_last;
    assign io_stream.out_last     = w_out_valid && w_i_last && w_j_last;

endmodule

// File: tb/tb_transpose_stream.sv
// Directed bench for transpose_stream: a 2x3 instance for the main scenarios and a 1x4 instance
// for the degenerate single-row case. Expectations follow TRANSPOSE_STREAM_PINGPONG_EN if defined.
module tb_transpose_stream;
    localparam int DW = 8;

    logic clk_p = 1'b0;
    logic rst_p;

    always #5 clk_p = ~clk_p;

    transpose_stream_if #(.DATA_WIDTH(DW)) a_if ();
    transpose_stream_if #(.DATA_WIDTH(DW)) b_if ();

    transpose_stream #(
        .DATA_WIDTH    (DW),
        .INPUT_SHAPE_1 (2),
        .INPUT_SHAPE_2 (3)
    ) u_dut_a (
        .clk_p     (clk_p),
        .rst_p     (rst_p),
        .io_stream (a_if.slave)
    );

    transpose_stream #(
        .DATA_WIDTH    (DW),
        .INPUT_SHAPE_1 (1),
        .INPUT_SHAPE_2 (4)
    ) u_dut_b (
        .clk_p     (clk_p),
        .rst_p     (rst_p),
        .io_stream (b_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_in     = 0;
    int last_in_cyc = 0;
    int q_data[$];
    int q_rl[$];
    int q_l[$];
    int q_cyc[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Called #1 after inputs are driven: records transfers, then advances one clock.
    task automatic tick_a();
        if (a_if.in_valid && a_if.in_ready) begin
            n_in++;
            last_in_cyc = cyc;
        end
        if (a_if.out_valid && a_if.out_ready) begin
            q_data.push_back(int'(a_if.out_data));
            q_rl.push_back(int'(a_if.out_row_last));
            q_l.push_back(int'(a_if.out_last));
            q_cyc.push_back(cyc);
        end
        @(posedge clk_p);
        @(negedge clk_p);
        cyc++;
    endtask

    task automatic stream_a(input string s, input int base, input int n_mat, input int gap,
                            input bit stall, input int stop);
        int off[6] = '{0, 3, 1, 4, 2, 5};
        int t = 0;
        int prev;
        bit was_stall;
        int sd, srl, sl;
        q_data.delete(); q_rl.delete(); q_l.delete(); q_cyc.delete();
        n_in = 0;
        while (q_data.size() < stop && t < 300) begin
            a_if.in_valid  = (n_in < 6 * n_mat) && (t % gap == 0);
            a_if.in_data   = DW'(base + n_in);
            a_if.out_ready = stall ? (t % 3 == 0) : 1'b1;
            #1;
            was_stall = a_if.out_valid && !a_if.out_ready;
            sd  = int'(a_if.out_data);
            srl = int'(a_if.out_row_last);
            sl  = int'(a_if.out_last);
`ifndef TRANSPOSE_STREAM_PINGPONG_EN
            if (a_if.out_valid) check({s, " in_ready low in drain"}, int'(a_if.in_ready), 0);
`endif
            prev = q_data.size();
            tick_a();
            #1;
            if (was_stall) begin
                check({s, " hold valid"}, int'(a_if.out_valid), 1);
                check({s, " hold data"}, int'(a_if.out_data), sd);
                check({s, " hold row_last"}, int'(a_if.out_row_last), srl);
                check({s, " hold last"}, int'(a_if.out_last), sl);
            end
            if (q_data.size() > prev && q_l[$] == 1) begin
                check({s, " in_ready after out_last"}, int'(a_if.in_ready), 1);
            end
            t++;
        end
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b0;
        check({s, " beat count"}, q_data.size(), stop);
        for (int k = 0; k < q_data.size(); k++) begin
            check($sformatf("%s data[%0d]", s, k), q_data[k], base + 6 * (k / 6) + off[k % 6]);
            check($sformatf("%s row_last[%0d]", s, k), q_rl[k], (k % 6) % 2);
            check($sformatf("%s last[%0d]", s, k), q_l[k], int'(k % 6 == 5));
        end
        if (n_mat == 1 && !stall && q_cyc.size() > 0) begin
            check({s, " first out latency"}, q_cyc[0] - last_in_cyc, 1);
        end
    endtask

    task automatic check_reset_outputs(input string s);
        check({s, " in_ready"}, int'(a_if.in_ready), 0);
        check({s, " out_valid"}, int'(a_if.out_valid), 0);
        check({s, " row_last"}, int'(a_if.out_row_last), 0);
        check({s, " last"}, int'(a_if.out_last), 0);
        check({s, " data"}, int'(a_if.out_data), 0);
    endtask

    initial begin
        int b_exp[4] = '{5, -3, 127, -128};
        int b_got[$];
        int b_rl[$];
        int b_l[$];
        int bi;

        rst_p = 1'b1;
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
        @(negedge clk_p);
        @(negedge clk_p);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_p);
        rst_p = 1'b0;
        #1;
        check("post-reset in_ready", int'(a_if.in_ready), 1);
        check("post-reset out_valid", int'(a_if.out_valid), 0);
        @(negedge clk_p);

        stream_a("s1", 1, 1, 1, 1'b0, 6);
        stream_a("s2", 21, 1, 1, 1'b1, 6);
        stream_a("s3", 41, 1, 3, 1'b0, 6);

        // Reset in the middle of a drain, then a fresh matrix.
        stream_a("s4a", 1, 1, 1, 1'b0, 3);
        rst_p = 1'b1;
        a_if.in_valid = 1'b1; a_if.in_data = DW'(99); a_if.out_ready = 1'b1;
        #1;
        check_reset_outputs("s4 rst c0");
        @(negedge clk_p);
        #1;
        check_reset_outputs("s4 rst c1");
        @(negedge clk_p);
        rst_p = 1'b0;
        a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
        #1;
        check("s4 in_ready after rst", int'(a_if.in_ready), 1);
        check("s4 out_valid after rst", int'(a_if.out_valid), 0);
        @(negedge clk_p);
        stream_a("s4", 7, 1, 1, 1'b0, 6);

        // Two back-to-back matrices with continuous valid.
        stream_a("s5", 1, 2, 1, 1'b0, 12);
        if (q_cyc.size() == 12) begin
`ifdef TRANSPOSE_STREAM_PINGPONG_EN
            check("s5 gap between matrices", q_cyc[6] - q_cyc[5], 1);
`else
            check("s5 gap between matrices", q_cyc[6] - q_cyc[5], 7);
`endif
        end

        // Single-row matrix on the 1x4 instance.
        bi = 0;
        for (int t = 0; t < 40 && b_got.size() < 4; t++) begin
            b_if.in_valid  = (bi < 4);
            b_if.in_data   = DW'(b_exp[bi < 4 ? bi : 0]);
            b_if.out_ready = 1'b1;
            #1;
            if (b_if.in_valid && b_if.in_ready) bi++;
            if (b_if.out_valid && b_if.out_ready) begin
                b_got.push_back(int'(b_if.out_data));
                b_rl.push_back(int'(b_if.out_row_last));
                b_l.push_back(int'(b_if.out_last));
            end
            @(negedge clk_p);
        end
        b_if.in_valid = 1'b0;
        check("s6 beat count", b_got.size(), 4);
        for (int k = 0; k < b_got.size(); k++) begin
            check($sformatf("s6 data[%0d]", k), b_got[k], b_exp[k]);
            check($sformatf("s6 row_last[%0d]", k), b_rl[k], 1);
            check($sformatf("s6 last[%0d]", k), b_l[k], int'(k == 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
